// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle Hack-compatible core with valid-handshaked fetch and data reads.
// Define CPU_HALT_EN to stop the core in a HALT state on an unconditional jump-to-self.
module cpu_multicycle #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc_out,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              instr_valid,
    output logic              mem_re,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              halted
);
    typedef enum logic [1:0] {FETCH, MREAD, EXEC, HALT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PC_W-1:0]  r_pc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mdr;

    logic             w_is_c;
    logic             w_dst_a;
    logic             w_dst_d;
    logic             w_dst_m;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_alu;
    logic             w_zr;
    logic             w_ng;
    logic             w_jmp;

    assign w_is_c  = r_ir[WIDTH-1];
    assign w_dst_a = !w_is_c || r_ir[5];
    assign w_dst_d = w_is_c && r_ir[4];
    assign w_dst_m = w_is_c && r_ir[3];

    // Hack ALU: zx,nx,zy,ny,f,no in ir[11:6]
    always_comb begin
        w_x = r_d;
        w_y = r_ir[12] ? r_mdr : r_a;
        if (r_ir[11]) w_x = '0;
        if (r_ir[10]) w_x = ~w_x;
        if (r_ir[9])  w_y = '0;
        if (r_ir[8])  w_y = ~w_y;
        w_alu = r_ir[7] ? (w_x + w_y) : (w_x & w_y);
        if (r_ir[6])  w_alu = ~w_alu;
    end

    assign w_zr  = (w_alu == '0);
    assign w_ng  = w_alu[WIDTH-1];
    assign w_jmp = w_is_c && ((r_ir[2] && w_ng) ||
                              (r_ir[1] && w_zr) ||
                              (r_ir[0] && !w_ng && !w_zr));

`ifdef CPU_HALT_EN
    logic w_self;
    assign w_self = w_is_c && (&r_ir[2:0]) &&
                    (r_a[PC_W-1:0] == r_pc);
    assign halted = (r_state == HALT);
`else
    assign halted = 1'b0;
`endif

    assign pc_out    = r_pc;
    assign mem_addr  = r_a[ADDR_W-1:0];
    assign mem_wdata = w_alu;

    always_comb begin
        w_next    = r_state;
        instr_req = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    if (instruction[WIDTH-1] && instruction[12])
                        w_next = MREAD;
                    else
                        w_next = EXEC;
                end
            end
            MREAD: begin
                mem_re = 1'b1;
                if (mem_rvalid) w_next = EXEC;
            end
            EXEC: begin
                mem_we = w_dst_m;
                w_next = FETCH;
`ifdef CPU_HALT_EN
                if (w_self) w_next = HALT;
`endif
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && instr_valid)
                r_ir <= instruction;
            if (r_state == MREAD && mem_rvalid)
                r_mdr <= mem_rdata;
            // jump target and write address both use the pre-update A
            if (r_state == EXEC) begin
                if (w_dst_a)
                    r_a <= w_is_c ? w_alu : {1'b0, r_ir[WIDTH-2:0]};
                if (w_dst_d)
                    r_d <= w_alu;
                r_pc <= w_jmp ? r_a[PC_W-1:0] : r_pc + PC_W'(1);
            end
        end
    end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle Hack-compatible CPU core. It decouples instruction fetch and data-memory reads through valid handshakes, so it can run against wait-stated memories (block RAM, SDRAM bridges, memory-mapped peripherals). Data width, data-address width and PC width are generic. The core sits between the instruction ROM port and the data memory/IO interconnect.

Parameters:
WIDTH, 16, data/register/instruction width; must be >= 16
ADDR_W, 15, data address width; must be <= WIDTH-1
PC_W, 16, program counter width; must be <= WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
instr_req  output  1  high while the core waits for an instruction at pc_out
pc_out  output  PC_W  address of the instruction being fetched
instruction  input  WIDTH  instruction word; sampled when instr_req && instr_valid
instr_valid  input  1  instruction word valid
mem_re  output  1  data read request; held until mem_rvalid
mem_rdata  input  WIDTH  read data; sampled when mem_re && mem_rvalid
mem_rvalid  input  1  read data valid; may assert in the same cycle as mem_re
mem_we  output  1  single-cycle write strobe; writes are always accepted
mem_addr  output  ADDR_W  data address = A[ADDR_W-1:0]
mem_wdata  output  WIDTH  ALU result
halted  output  1  core halted (see Optional Feature)

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset.
- Reset values: state=FETCH; PC=0, A=0, D=0, IR=0, MDR=0. Outputs after reset: instr_req=1, mem_re=0, mem_we=0, halted=0, pc_out=0.
- Decode:
  - bit WIDTH-1 = 0: A-instruction. A <= zero-extended instruction[WIDTH-2:0].
  - bit WIDTH-1 = 1: C-instruction. Fields: a=bit12, comp=bits11:6 (zx,nx,zy,ny,f,no), dest=bits5:3 (A,D,M), jump=bits2:0.
  - Bits WIDTH-2:13 are ignored.
- ALU: Hack semantics at WIDTH bits. x=D; y = a ? MDR : A. f=1 selects x+y (mod 2^WIDTH), f=0 selects x&y. zr = (out==0); ng = out[WIDTH-1].
- State FETCH: instr_req=1.
  - On instr_valid: IR <= instruction.
  - Next state is MREAD if C-instruction with a=1, else EXEC.
- State MREAD: mem_re=1, mem_addr=A.
  - On mem_rvalid: MDR <= mem_rdata, next state EXEC.
  - Otherwise stay in MREAD with mem_re held high.
- State EXEC: one cycle.
  - mem_we = C && dest[M]; mem_addr and mem_wdata are taken from pre-update A and ALU output.
  - A and D are written per dest (A-instructions write A only).
  - Jump evaluated from zr/ng: 000 none, 001 >0, 010 =0, 011 >=0, 100 <0, 101 !=0, 110 <=0, 111 always. Never taken for A-instructions.
  - PC <= taken ? old A[PC_W-1:0] : PC+1, wrapping mod 2^PC_W.
  - Next state FETCH.
- Simultaneous A-dest and jump: the jump target and write address use old A.
- Latency: A-instruction or non-M C-instruction takes 2 cycles minimum. M-reading C-instruction takes 3 cycles plus wait cycles. instr_valid low stalls FETCH indefinitely.
- mem_re and mem_we are never high in the same cycle. instr_req is low outside FETCH.
- Reset mid-operation: the pending fetch/read is abandoned. A late mem_rvalid or instr_valid outside its owning state is ignored.

Optional Feature:
Macro CPU_HALT_EN.
- Defined: in EXEC, a C-instruction with jump=111 and old A[PC_W-1:0]==PC enters state HALT.
  - In HALT: halted=1, instr_req=0, mem_re=0, mem_we=0, no register changes.
  - Only reset exits HALT.
  - Any M write of the halting instruction still occurs in its EXEC cycle.
- Undefined: no HALT state; halted tied 0; a jump-to-self loops through FETCH/EXEC forever.

Test Plan:
1. Reset, then 0x0005 with instr_valid held high -> after 2 cycles A=5, pc_out=1, mem_we never asserted.
2. Program 0x0005, 0xEC10, 0x0007, 0xE090 (D=A; D=D+A) -> D=12, pc_out=4 after 8 cycles.
3. A=3, then 0xFC10 (D=M), mem_rvalid held low 3 cycles then high with 0x1234 -> mem_re high 4 cycles, mem_addr=3, D=0x1234, instruction takes 6 cycles.
4. A=9, 0xEE90 (D=-1), 0xE308 (M=D) -> exactly one mem_we pulse with mem_addr=9, mem_wdata=0xFFFF.
5. A=10, D=0, 0xE302 (D;JEQ) -> pc_out=10. Repeat with D=1 -> pc_out=PC+1. Jump at PC=0xFFFF not taken -> pc_out=0.
6. With CPU_HALT_EN: at PC=4, 0x0005 then 0xEA87 (0;JMP to 5) -> halted=1, instr_req=0. Assert reset for 1 cycle -> halted=0, pc_out=0. Without the macro -> halted stays 0 and pc_out stays 5.
